// File: rtl/io_capture_pkg.sv
// io_capture_pkg: shared state enum, default sync word and FIFO word type for io_capture_ctrl
package io_capture_pkg;
    typedef enum logic [1:0] {IDLE, HUNT, STREAM, CHECK} cap_state_e;
    localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hA5C3;
    typedef struct packed {
        logic        last;
        logic [15:0] data;
    } cap_word_t;
endpackage

// File: rtl/io_capture_ctrl_if.sv
// io_capture_ctrl_if: payload valid/ready stream from io_capture_ctrl to the demodulator
interface io_capture_ctrl_if;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_last;
    logic        m_ready;
    modport master (output m_valid, m_data, m_last, input m_ready);
    modport slave (input m_valid, m_data, m_last, output m_ready);
endinterface

// File: rtl/io_capture_ctrl_cap_fifo.sv
// cap_fifo: synchronous payload FIFO of cap_word_t; head is presented straight from storage flops
module cap_fifo import io_capture_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    input  logic      push,
    input  logic      pop,
    input  cap_word_t push_word,
    output cap_word_t out_word,
    output logic      full,
    output logic      empty
);
    localparam int AW = $clog2(DEPTH);
    cap_word_t     mem_q [DEPTH];
    cap_word_t     mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    assign full     = cnt_q == (AW+1)'(DEPTH);
    assign empty    = cnt_q == '0;
    assign out_word = mem_q[rd_q];
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_q] = push_word;
        wr_d  = flush ? '0 : wr_q + AW'(push);
        rd_d  = flush ? '0 : rd_q + AW'(pop);
        cnt_d = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/io_capture_ctrl.sv
// io_capture_ctrl: sync hunt and flywheel frame lock feeding a payload FIFO stream.
// Define IO_CAPTURE_STATS_EN to add the frame_cnt output.
module io_capture_ctrl import io_capture_pkg::*; #(
    parameter int          FRAME_LEN     = 64,
    parameter logic [15:0] SYNC_WORD     = SYNC_WORD_DEFAULT,
    parameter int          FIFO_DEPTH    = 4,
    parameter int          LOCK_MISS_MAX = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [15:0]              sample_in,
    io_capture_ctrl_if.master        m,
    output logic                     locked,
    output logic                     overflow
`ifdef IO_CAPTURE_STATS_EN
    ,
    output logic [15:0]              frame_cnt
`endif
);
    localparam int CW = $clog2(FRAME_LEN);
    localparam int MW = $clog2(LOCK_MISS_MAX + 1);
    cap_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [MW-1:0] miss_q, miss_d;
    logic          locked_q, locked_d, ovf_q, ovf_d;
    logic          full, empty, pop, push, push_ok, sync_hit, last_word;
    cap_word_t     push_word, out_word;
    assign sync_hit  = sample_in == SYNC_WORD;
    assign last_word = cnt_q == CW'(FRAME_LEN - 1);
    assign pop       = !empty && m.m_ready;
    assign push      = enable && state_q == STREAM;
    // a full FIFO still takes the word when the head leaves in the same cycle
    assign push_ok   = push && (!full || pop);
    assign push_word = '{last: last_word, data: sample_in};
    cap_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (!enable),
        .push      (push_ok),
        .pop       (pop),
        .push_word (push_word),
        .out_word  (out_word),
        .full      (full),
        .empty     (empty)
    );
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        miss_d   = miss_q;
        locked_d = locked_q;
        ovf_d    = ovf_q || (push && !push_ok);
        if (!enable) begin
            state_d  = IDLE;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = HUNT;
                    ovf_d   = 1'b0;
                end
                HUNT: if (sync_hit) begin
                    state_d  = STREAM;
                    cnt_d    = '0;
                    miss_d   = '0;
                    locked_d = 1'b1;
                end
                STREAM: begin
                    cnt_d   = last_word ? '0 : cnt_q + CW'(1);
                    state_d = last_word ? CHECK : STREAM;
                end
                CHECK: begin
                    // a missed sync slot is swallowed as if it were the sync word
                    miss_d = sync_hit ? '0 : miss_q + MW'(1);
                    if (!sync_hit && int'(miss_q) + 1 >= LOCK_MISS_MAX) begin
                        state_d  = HUNT;
                        locked_d = 1'b0;
                    end else begin
                        state_d = STREAM;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            miss_q   <= '0;
            locked_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            miss_q   <= miss_d;
            locked_q <= locked_d;
            ovf_q    <= ovf_d;
        end
    end
    assign m.m_valid = !empty;
    assign m.m_data  = out_word.data;
    assign m.m_last  = out_word.last;
    assign locked    = locked_q;
    assign overflow  = ovf_q;
`ifdef IO_CAPTURE_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    assign frame_cnt_d = frame_cnt_q + 16'(pop && out_word.last);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) frame_cnt_q <= '0;
        else frame_cnt_q <= frame_cnt_d;
    end
    assign frame_cnt = frame_cnt_q;
`endif
endmodule

// File: tb/tb_io_capture_ctrl.sv
// tb_io_capture_ctrl: directed and random frames checked against a queue-based frame model
module tb_io_capture_ctrl;
    import io_capture_pkg::*;
    localparam int          L  = 64;
    localparam int          D  = 4;
    localparam int          MM = 2;
    localparam logic [15:0] SW = 16'hA5C3;
    logic        clk = 1'b0;
    logic        rst, enable, locked, overflow;
    logic [15:0] sample_in;
`ifdef IO_CAPTURE_STATS_EN
    logic [15:0] frame_cnt;
`endif
    int n_vec = 0;
    int n_err = 0;
    // model: pos -2 idle, -1 hunting, 0..L-1 next payload index, L sync slot
    int        pos, misses, frames;
    bit        mlock, movf, mon63;
    cap_word_t q[$];
    io_capture_ctrl_if m();
    io_capture_ctrl #(.FRAME_LEN(L), .SYNC_WORD(SW), .FIFO_DEPTH(D), .LOCK_MISS_MAX(MM)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .sample_in (sample_in),
        .m         (m),
        .locked    (locked),
        .overflow  (overflow)
`ifdef IO_CAPTURE_STATS_EN
        ,
        .frame_cnt (frame_cnt)
`endif
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic mreset();
        pos = -2; misses = 0; frames = 0; mlock = 0; movf = 0;
        q.delete();
    endtask
    task automatic model_step();
        bit pop;
        pop = q.size() != 0 && m.m_ready;
        if (pop) begin
            if (q[0].last) frames++;
            void'(q.pop_front());
        end
        if (!enable) begin
            pos = -2; mlock = 0;
            q.delete();
        end else if (pos == -2) begin
            pos = -1; movf = 0;
        end else if (pos == -1) begin
            if (sample_in == SW) begin pos = 0; misses = 0; mlock = 1; end
        end else if (pos < L) begin
            if (q.size() < D) q.push_back('{last: (pos == L - 1), data: sample_in});
            else movf = 1;
            pos++;
        end else if (sample_in == SW) begin
            misses = 0; pos = 0;
        end else if (misses + 1 < MM) begin
            misses++; pos = 0;
        end else begin
            mlock = 0; pos = -1;
        end
    endtask
    task automatic check_all();
        chk("m_valid", m.m_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("m_data", m.m_data, q[0].data);
            chk("m_last", m.m_last, q[0].last);
        end
        chk("locked", locked, mlock);
        chk("overflow", overflow, movf);
`ifdef IO_CAPTURE_STATS_EN
        chk("frame_cnt", frame_cnt, 16'(frames));
`endif
    endtask
    task automatic cyc(input logic en, input logic [15:0] s, input logic rdy);
        enable = en; sample_in = s; m.m_ready = rdy;
        if (mon63 && m.m_valid && rdy && m.m_last) chk("last_at_63", m.m_data[7:0], 8'd63);
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask
    task automatic payload(input int fid, input int from, input int to, input logic rdy);
        for (int i = from; i <= to; i++) cyc(1'b1, {8'(fid), 8'(i)}, rdy);
    endtask
    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, m.m_valid, 0);
        chk({tag, "_data"}, m.m_data, 0);
        chk({tag, "_last"}, m.m_last, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_ovf"}, overflow, 0);
`ifdef IO_CAPTURE_STATS_EN
        chk({tag, "_fcnt"}, frame_cnt, 0);
`endif
    endtask
    initial begin
        rst = 1'b1; enable = 1'b0; sample_in = '0; m.m_ready = 1'b0; mon63 = 1;
        mreset();
        #12;
        check_zero("reset");
        rst = 1'b0;
        cyc(1'b1, 16'h1234, 1'b1);
        cyc(1'b1, 16'h0000, 1'b1);
        cyc(1'b1, SW, 1'b1);
        chk("lock_after_sync", locked, 1);
        payload(0, 0, 62, 1'b1);
        chk("w62_data", m.m_data, 16'd62);
        chk("w62_last", m.m_last, 0);
        cyc(1'b1, 16'd63, 1'b1);
        chk("w63_data", m.m_data, 16'd63);
        chk("w63_last", m.m_last, 1);
        cyc(1'b1, SW, 1'b1);
        chk("slot_drain", m.m_valid, 0);
        payload(1, 0, 63, 1'b1);
        cyc(1'b1, 16'h0000, 1'b1);
        chk("fly_one_miss", locked, 1);
        payload(2, 0, 63, 1'b1);
        cyc(1'b1, SW, 1'b1);
        payload(3, 0, 63, 1'b1);
        cyc(1'b1, 16'h0000, 1'b1);
        chk("fly_miss_a", locked, 1);
        payload(4, 0, 63, 1'b1);
        cyc(1'b1, 16'h0000, 1'b1);
        chk("fly_miss_b", locked, 0);
        chk("fly_state", 32'(dut.state_q), 32'(HUNT));
        cyc(1'b1, SW, 1'b1);
        payload(5, 0, 19, 1'b1);
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, {8'd5, 8'(20 + k)}, 1'b0);
            chk("bp_hold", m.m_data, {8'd5, 8'd19});
            if (k == 2) chk("bp_no_ovf", overflow, 0);
            if (k == 3) chk("bp_ovf", overflow, 1);
        end
        payload(5, 30, 63, 1'b1);
        cyc(1'b1, SW, 1'b1);
        payload(6, 0, 63, 1'b1);
        cyc(1'b1, SW, 1'b1);
        payload(7, 0, 19, 1'b1);
        cyc(1'b0, {8'd7, 8'd20}, 1'b1);
        chk("abort_valid", m.m_valid, 0);
        chk("abort_locked", locked, 0);
        chk("abort_ovf_kept", overflow, 1);
        cyc(1'b0, 16'h0000, 1'b1);
        cyc(1'b1, 16'h0000, 1'b1);
        chk("reenable_ovf_clr", overflow, 0);
        cyc(1'b1, SW, 1'b1);
        payload(8, 0, 9, 1'b1);
        payload(8, 10, 12, 1'b0);
        cyc(1'b1, {8'd8, 8'd13}, 1'b1);
        chk("full_pop_no_ovf", overflow, 0);
        payload(8, 14, 63, 1'b1);
        cyc(1'b1, SW, 1'b1);
        payload(9, 0, 63, 1'b1);
        mon63 = 0;
        for (int f = 0; f < 8; f++) begin
            if (f == 4) begin
                cyc(1'b0, 16'($urandom), 1'b1);
                cyc(1'b1, 16'($urandom), 1'b1);
            end
            cyc(1'b1, ($urandom_range(0, 4) == 0) ? 16'($urandom) : SW, $urandom_range(0, 3) != 0);
            for (int i = 0; i < L; i++) cyc(1'b1, 16'($urandom), $urandom_range(0, 3) != 0);
        end
        cyc(1'b1, SW, 1'b1);
        payload(10, 0, 30, 1'b1);
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        mreset();
        rst = 1'b0;
        mon63 = 1;
        cyc(1'b1, 16'h0000, 1'b1);
        cyc(1'b1, SW, 1'b1);
        payload(11, 0, 63, 1'b1);
        cyc(1'b1, SW, 1'b1);
        payload(12, 0, 3, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
